// File: rtl/vga_timing_pkg.sv
// Shared types and elaboration helpers for the video timing generator.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PAT_BLACK = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_GRID  = 2'd2,
    PAT_GRAD  = 2'd3
  } pattern_t;

  function automatic int h_total(input int visible, input int front, input int pulse,
                                 input int back);
    return visible + front + pulse + back;
  endfunction

  function automatic int v_total(input int visible, input int front, input int pulse,
                                 input int back);
    return visible + front + pulse + back;
  endfunction

  // True when an unsigned counter of 'bits' width can hold 'value'.
  function automatic bit fits_bits(input int value, input int bits);
    if (bits >= 31) return 1'b1;
    return (value >= 0) && (value < (1 << bits));
  endfunction

  // The fetch look-ahead has to land inside the horizontal blanking interval.
  function automatic bit lead_ok(input int lead, input int total, input int visible);
    return (lead > 0) && (lead < (total - visible));
  endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Test-pattern source: latches the pattern mode at frame wrap and produces
// registered colour with the same latency as the timing outputs.
module vga_pattern_gen
  import vga_timing_pkg::*;
#(
  parameter int C_bits_x       = 11,
  parameter int C_bits_y       = 11,
  parameter int C_resolution_x = 1024
) (
  input  logic                clk_pixel,
  input  logic                reset,
  input  logic                enable,
  input  logic                latch,
  input  logic [1:0]          pattern_sel,
  input  logic [C_bits_x-1:0] x,
  input  logic [C_bits_y-1:0] y,
  input  logic                visible,
  input  logic [7:0]          frame_low,
  output logic [7:0]          vga_r,
  output logic [7:0]          vga_g,
  output logic [7:0]          vga_b
);

  // Bar width; the last bar absorbs whatever res_x/8 leaves over.
  localparam int BAR_W = (C_resolution_x >= 8) ? (C_resolution_x / 8) : 1;
  localparam logic [C_bits_x-1:0] BAR_W_V   = C_bits_x'(BAR_W);
  localparam logic [C_bits_x-1:0] BAR_MAX_V = C_bits_x'(7);

  pattern_t            mode;
  logic [C_bits_x-1:0] bar_q;
  logic [2:0]          bar;
  logic [7:0]          x_low;
  logic [7:0]          y_low;
  logic                grid_on;
  logic [7:0]          r_nxt;
  logic [7:0]          g_nxt;
  logic [7:0]          b_nxt;

  assign bar_q   = x / BAR_W_V;
  assign bar     = (bar_q > BAR_MAX_V) ? 3'd7 : bar_q[2:0];
  assign x_low   = 8'(x);
  assign y_low   = 8'(y);
  assign grid_on = (x_low[4:0] == 5'd0) || (y_low[4:0] == 5'd0);

  // Colour for the pixel at (x, y) under the currently latched mode.
  always_comb begin
    r_nxt = 8'd0;
    g_nxt = 8'd0;
    b_nxt = 8'd0;
    if (visible) begin
      case (mode)
        PAT_BARS: begin
          r_nxt = {8{bar[2]}};
          g_nxt = {8{bar[1]}};
          b_nxt = {8{bar[0]}};
        end
        PAT_GRID: begin
          r_nxt = {8{grid_on}};
          g_nxt = {8{grid_on}};
          b_nxt = {8{grid_on}};
        end
        PAT_GRAD: begin
          r_nxt = x_low;
          g_nxt = y_low;
          b_nxt = frame_low;
        end
        default: begin
          r_nxt = 8'd0;
          g_nxt = 8'd0;
          b_nxt = 8'd0;
        end
      endcase
    end
  end

  // Mode latch at frame wrap plus the colour output register; both freeze with enable.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      mode  <= PAT_BLACK;
      vga_r <= 8'd0;
      vga_g <= 8'd0;
      vga_b <= 8'd0;
    end else if (enable) begin
      if (latch) mode <= pattern_t'(pattern_sel);
      vga_r <= r_nxt;
      vga_g <= g_nxt;
      vga_b <= b_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Video timing generator: pixel/line counters, registered syncs and blank,
// early pixel-fetch look-ahead, line/frame strobes, frame counter and test patterns.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int C_resolution_x      = 1024,
  parameter int C_hsync_front_porch = 16,
  parameter int C_hsync_pulse       = 96,
  parameter int C_hsync_back_porch  = 44,
  parameter int C_resolution_y      = 768,
  parameter int C_vsync_front_porch = 10,
  parameter int C_vsync_pulse       = 2,
  parameter int C_vsync_back_porch  = 31,
  parameter int C_bits_x            = 11,
  parameter int C_bits_y            = 11,
  parameter int C_hsync_polarity    = 0,
  parameter int C_vsync_polarity    = 0,
  parameter int C_fetch_lead        = 2,
  parameter int C_bits_frame        = 16
) (
  input  logic                    clk_pixel,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              pattern_sel,
  output logic                    fetch,
  output logic [C_bits_x-1:0]     fetch_x,
  output logic [C_bits_y-1:0]     fetch_y,
  output logic [C_bits_x-1:0]     beam_x,
  output logic [C_bits_y-1:0]     beam_y,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic                    vga_blank,
  output logic [7:0]              vga_r,
  output logic [7:0]              vga_g,
  output logic [7:0]              vga_b,
  output logic                    line_start,
  output logic                    frame_start,
  output logic [C_bits_frame-1:0] frame_count
);

  localparam int H_TOTAL  = h_total(C_resolution_x, C_hsync_front_porch, C_hsync_pulse,
                                    C_hsync_back_porch);
  localparam int V_TOTAL  = v_total(C_resolution_y, C_vsync_front_porch, C_vsync_pulse,
                                    C_vsync_back_porch);
  localparam int HS_START = C_resolution_x + C_hsync_front_porch;
  localparam int VS_START = C_resolution_y + C_vsync_front_porch;

  localparam logic [C_bits_x-1:0] RES_X_V    = C_bits_x'(C_resolution_x);
  localparam logic [C_bits_x-1:0] H_LAST_V   = C_bits_x'(H_TOTAL - 1);
  localparam logic [C_bits_x-1:0] HS_FIRST_V = C_bits_x'(HS_START);
  localparam logic [C_bits_x-1:0] HS_LAST_V  = C_bits_x'(HS_START + C_hsync_pulse - 1);
  localparam logic [C_bits_x:0]   LEAD_V     = (C_bits_x+1)'(C_fetch_lead);
  localparam logic [C_bits_x:0]   H_TOTAL_V  = (C_bits_x+1)'(H_TOTAL);
  localparam logic [C_bits_y-1:0] RES_Y_V    = C_bits_y'(C_resolution_y);
  localparam logic [C_bits_y-1:0] V_LAST_V   = C_bits_y'(V_TOTAL - 1);
  localparam logic [C_bits_y-1:0] VS_FIRST_V = C_bits_y'(VS_START);
  localparam logic [C_bits_y-1:0] VS_LAST_V  = C_bits_y'(VS_START + C_vsync_pulse - 1);
  localparam logic                HS_ON      = (C_hsync_polarity != 0);
  localparam logic                VS_ON      = (C_vsync_polarity != 0);

  if (!fits_bits(H_TOTAL - 1, C_bits_x)) begin : g_bad_bits_x
    $error("vga_timing_gen: C_bits_x cannot hold H_total-1");
  end
  if (!fits_bits(V_TOTAL - 1, C_bits_y)) begin : g_bad_bits_y
    $error("vga_timing_gen: C_bits_y cannot hold V_total-1");
  end
  if (!lead_ok(C_fetch_lead, H_TOTAL, C_resolution_x)) begin : g_bad_lead
    $error("vga_timing_gen: C_fetch_lead must lie in (0, H_total-C_resolution_x)");
  end

  logic [C_bits_x-1:0]     cx;
  logic [C_bits_y-1:0]     cy;
  logic                    cx_last;
  logic                    cy_last;
  logic                    at_origin;
  logic                    visible;
  logic                    hs_act;
  logic                    vs_act;
  logic [C_bits_x:0]       la_sum;
  logic                    la_wrap;
  logic [C_bits_x-1:0]     la_x;
  logic [C_bits_y-1:0]     la_y;
  logic                    la_vis;
  logic                    frame_done;
  logic                    count_now;
  logic [C_bits_frame-1:0] frame_count_nxt;

  assign cx_last   = (cx == H_LAST_V);
  assign cy_last   = (cy == V_LAST_V);
  assign at_origin = (cx == '0) && (cy == '0);
  assign visible   = (cx < RES_X_V) && (cy < RES_Y_V);
  assign hs_act    = (cx >= HS_FIRST_V) && (cx <= HS_LAST_V);
  assign vs_act    = (cy >= VS_FIRST_V) && (cy <= VS_LAST_V);

  // Look-ahead position C_fetch_lead pixels ahead, crossing line and frame wrap.
  assign la_sum  = {1'b0, cx} + LEAD_V;
  assign la_wrap = (la_sum >= H_TOTAL_V);
  assign la_x    = la_wrap ? C_bits_x'(la_sum - H_TOTAL_V) : C_bits_x'(la_sum);
  assign la_y    = la_wrap ? (cy_last ? '0 : cy + 1'b1) : cy;
  assign la_vis  = (la_x < RES_X_V) && (la_y < RES_Y_V);

  // A frame counts as completed only once the counters have wrapped back to the origin,
  // so the first frame after reset does not count itself.
  assign count_now       = enable && at_origin && frame_done;
  assign frame_count_nxt = count_now ? frame_count + 1'b1 : frame_count;

  // Raster counters: cx runs across the line, cy advances on each cx wrap.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      cx <= '0;
      cy <= '0;
    end else if (enable) begin
      if (cx_last) begin
        cx <= '0;
        cy <= cy_last ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  // Registered timing outputs, one cycle behind the counters; frozen when disabled
  // except for the strobes and fetch, which drop to zero.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      beam_x      <= '0;
      beam_y      <= '0;
      vga_blank   <= 1'b1;
      vga_hsync   <= ~HS_ON;
      vga_vsync   <= ~VS_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      fetch       <= 1'b0;
      fetch_x     <= '0;
      fetch_y     <= '0;
    end else if (enable) begin
      beam_x      <= cx;
      beam_y      <= cy;
      vga_blank   <= ~visible;
      vga_hsync   <= hs_act ? HS_ON : ~HS_ON;
      vga_vsync   <= vs_act ? VS_ON : ~VS_ON;
      line_start  <= (cx == '0);
      frame_start <= at_origin;
      fetch       <= la_vis;
      if (la_vis) begin
        fetch_x <= la_x;
        fetch_y <= la_y;
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      fetch       <= 1'b0;
    end
  end

  // Completed-frame counter; steps on the same edge that raises frame_start.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else if (enable) begin
      frame_count <= frame_count_nxt;
      if (cx_last && cy_last) frame_done <= 1'b1;
      else if (at_origin)     frame_done <= 1'b0;
    end
  end

  vga_pattern_gen #(
    .C_bits_x       (C_bits_x),
    .C_bits_y       (C_bits_y),
    .C_resolution_x (C_resolution_x)
  ) u_pattern (
    .clk_pixel   (clk_pixel),
    .reset       (reset),
    .enable      (enable),
    .latch       (cx_last && cy_last),
    .pattern_sel (pattern_sel),
    .x           (cx),
    .y           (cy),
    .visible     (visible),
    .frame_low   (8'(frame_count_nxt)),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b)
  );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 16x4 raster (H_total 22, V_total 7).
module tb_vga_timing_gen;

  localparam int RX = 16;
  localparam int HT = 22;
  localparam int RY = 4;
  localparam int FT = 154;

  logic        clk_pixel = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        fetch;
  logic [10:0] fetch_x;
  logic [10:0] fetch_y;
  logic [10:0] beam_x;
  logic [10:0] beam_y;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_blank;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk_pixel = ~clk_pixel;

  vga_timing_gen #(
    .C_resolution_x      (16),
    .C_hsync_front_porch (2),
    .C_hsync_pulse       (3),
    .C_hsync_back_porch  (1),
    .C_resolution_y      (4),
    .C_vsync_front_porch (1),
    .C_vsync_pulse       (1),
    .C_vsync_back_porch  (1),
    .C_bits_x            (11),
    .C_bits_y            (11),
    .C_hsync_polarity    (0),
    .C_vsync_polarity    (0),
    .C_fetch_lead        (2),
    .C_bits_frame        (16)
  ) dut (
    .clk_pixel   (clk_pixel),
    .reset       (reset),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .fetch       (fetch),
    .fetch_x     (fetch_x),
    .fetch_y     (fetch_y),
    .beam_x      (beam_x),
    .beam_y      (beam_y),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync),
    .vga_blank   (vga_blank),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_pixel);
    @(negedge clk_pixel);
    cyc++;
  endtask

  task automatic check_reset_state;
    chk("rst_beam_x", 32'(beam_x), 0);
    chk("rst_beam_y", 32'(beam_y), 0);
    chk("rst_blank", 32'(vga_blank), 1);
    chk("rst_hsync", 32'(vga_hsync), 1);
    chk("rst_vsync", 32'(vga_vsync), 1);
    chk("rst_fetch", 32'(fetch), 0);
    chk("rst_fetch_x", 32'(fetch_x), 0);
    chk("rst_fetch_y", 32'(fetch_y), 0);
    chk("rst_line_start", 32'(line_start), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_rgb", {8'd0, vga_r, vga_g, vga_b}, 0);
  endtask

  // n = number of enabled clock edges since reset release.
  // Frame 0 is black (mode reset), frames 1-2 bars, frames 3+ gradient.
  task automatic check_pixel(input int n);
    int p, bx, by, f, pp, fx, fy, bar;
    logic vis, fvis;
    logic [7:0] er, eg, eb;
    p  = (n - 1) % FT;
    bx = p % HT;
    by = p / HT;
    f  = (n - 1) / FT;
    vis = (bx < RX) && (by < RY);
    pp = (n + 1) % FT;
    fx = pp % HT;
    fy = pp / HT;
    fvis = (fx < RX) && (fy < RY);
    er = 8'd0;
    eg = 8'd0;
    eb = 8'd0;
    if (vis) begin
      if (f == 1 || f == 2) begin
        bar = bx / 2;
        if (bar > 7) bar = 7;
        er = bar[2] ? 8'd255 : 8'd0;
        eg = bar[1] ? 8'd255 : 8'd0;
        eb = bar[0] ? 8'd255 : 8'd0;
      end else if (f >= 3) begin
        er = bx[7:0];
        eg = by[7:0];
        eb = f[7:0];
      end
    end
    chk("beam_x", 32'(beam_x), bx);
    chk("beam_y", 32'(beam_y), by);
    chk("blank", 32'(vga_blank), vis ? 0 : 1);
    chk("hsync", 32'(vga_hsync), (bx >= 18 && bx <= 20) ? 0 : 1);
    chk("vsync", 32'(vga_vsync), (by == 5) ? 0 : 1);
    chk("line_start", 32'(line_start), (bx == 0) ? 1 : 0);
    chk("frame_start", 32'(frame_start), (p == 0) ? 1 : 0);
    chk("frame_count", 32'(frame_count), f);
    chk("fetch", 32'(fetch), fvis ? 1 : 0);
    if (fvis) begin
      chk("fetch_x", 32'(fetch_x), fx);
      chk("fetch_y", 32'(fetch_y), fy);
    end
    chk("rgb", {8'd0, vga_r, vga_g, vga_b}, {8'd0, er, eg, eb});
  endtask

  initial begin
    reset       = 1'b0;
    enable      = 1'b0;
    pattern_sel = 2'd1;
    #2 reset = 1'b1;
    tick();
    tick();
    check_reset_state();

    // Release and run four frames; pattern_sel changes mid-frame 2.
    enable = 1'b1;
    reset  = 1'b0;
    cyc    = 0;
    for (int n = 1; n <= 624; n++) begin
      tick();
      check_pixel(n);
      if (n == 350) pattern_sel = 2'd3;
    end

    // Freeze for 10 cycles at beam_x=7 of frame 4's first line.
    enable = 1'b0;
    for (int h = 0; h < 10; h++) begin
      tick();
      chk("hold_beam_x", 32'(beam_x), 7);
      chk("hold_beam_y", 32'(beam_y), 0);
      chk("hold_blank", 32'(vga_blank), 0);
      chk("hold_hsync", 32'(vga_hsync), 1);
      chk("hold_rgb", {8'd0, vga_r, vga_g, vga_b}, {8'd0, 8'd7, 8'd0, 8'd4});
      chk("hold_fetch", 32'(fetch), 0);
      chk("hold_fetch_x", 32'(fetch_x), 9);
      chk("hold_line_start", 32'(line_start), 0);
      chk("hold_frame_start", 32'(frame_start), 0);
      chk("hold_frame_count", 32'(frame_count), 4);
    end

    // Resume from the held position; next frame_start arrives 164 cycles after the last.
    enable = 1'b1;
    for (int n = 625; n <= 834; n++) begin
      tick();
      check_pixel(n);
    end
    chk("pre_rst_hsync_active", 32'(vga_hsync), 0);
    chk("pre_rst_beam_y", 32'(beam_y), 2);

    // Asynchronous reset mid-line with hsync active: outputs drop immediately.
    reset = 1'b1;
    #1;
    check_reset_state();
    tick();
    tick();
    check_reset_state();
    reset = 1'b0;
    cyc   = 0;
    tick();
    chk("post_line_start", 32'(line_start), 1);
    chk("post_frame_start", 32'(frame_start), 1);
    chk("post_beam_x", 32'(beam_x), 0);
    chk("post_frame_count", 32'(frame_count), 0);
    chk("post_fetch_x", 32'(fetch_x), 2);
    tick();
    chk("post_line_start_2", 32'(line_start), 0);
    for (int k = 3; k <= 5; k++) tick();
    chk("post_beam_x_5", 32'(beam_x), 4);
    chk("post_rgb_black", {8'd0, vga_r, vga_g, vga_b}, 0);
    while (cyc < 155) tick();
    chk("post_frame_start_155", 32'(frame_start), 1);
    chk("post_frame_count_155", 32'(frame_count), 1);
    chk("post_grad_b", 32'(vga_b), 1);
    tick();
    chk("post_grad_r", 32'(vga_r), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
